// File: rtl/instr_encoder.sv
// Packs opcode/register/funct fields and an immediate into a RISC-V instruction word and
// streams it out with its byte address; wide ADDI immediates can be split into LUI+ADDI.
module instr_encoder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned START_ADDR = 0,
    parameter bit          EXPAND_EN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [2:0]        state_o
);

    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Both request (valid/ready) and output (instr_valid/instr_ready) channels transfer on a
    // clock edge where valid and ready are both high; a held valid keeps its payload stable.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_EMIT    = 3'd2,
        S_EMIT_HI = 3'd3,
        S_LO_GAP  = 3'd4,
        S_EMIT_LO = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [2:0]        f3_q, f3_d;
    logic [6:0]        f7_q, f7_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       lo_q, lo_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0] enc_word;
    logic [31:0] lui_word;
    logic [31:0] addi_word;
    logic [19:0] lui_hi;
    logic        legal;
    logic        expand;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        is_shift;

    // Format selection and range check on the registered request.
    always_comb begin
        enc_word = 32'd0;
        legal    = 1'b0;
        expand   = 1'b0;
        fits12   = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
        fits13   = (imm_q[31:12] == '0) || (imm_q[31:12] == '1);
        fits21   = (imm_q[31:20] == '0) || (imm_q[31:20] == '1);
        is_shift = (op_q == OP_I) && ((f3_q == 3'b001) || (f3_q == 3'b101));
        lui_hi   = imm_q[31:12] + {19'd0, imm_q[11]};
        lui_word = {lui_hi, rd_q, OP_LUI};
        addi_word = {imm_q[11:0], rd_q, 3'b000, rd_q, OP_I};
        case (op_q)
            OP_I, OP_LW, OP_JALR: begin
                if (is_shift) begin
                    enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
                    legal    = (imm_q[31:5] == '0);
                end else begin
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                    legal    = fits12;
                    expand   = EXPAND_EN && !fits12 && (op_q == OP_I) && (f3_q == 3'b000);
                end
            end
            OP_S: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                legal    = fits12;
            end
            OP_B: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
                legal    = fits13 && !imm_q[0];
            end
            OP_J: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                legal    = fits21 && !imm_q[0];
            end
            OP_AUIPC: begin
                enc_word = {imm_q[31:12], rd_q, op_q};
                legal    = (imm_q[11:0] == '0);
            end
            default: begin
                enc_word = 32'd0;
                legal    = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        imm_d   = imm_q;
        instr_d = instr_q;
        lo_d    = lo_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = opcode_i;
                    rd_d    = rd_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    f3_d    = funct3_i;
                    f7_d    = funct7_i;
                    imm_d   = imm_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (legal) begin
                    instr_d = enc_word;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else if (expand) begin
                    instr_d = lui_word;
                    lo_d    = addi_word;
                    valid_d = 1'b1;
                    state_d = S_EMIT_HI;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_EMIT, S_EMIT_LO: begin
                if (instr_ready_i) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = S_IDLE;
                end
            end
            S_EMIT_HI: begin
                if (instr_ready_i) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = S_LO_GAP;
                end
            end
            S_LO_GAP: begin
                // Valid stays low for this one cycle so the two beats are distinct.
                instr_d = lo_q;
                valid_d = 1'b1;
                state_d = S_EMIT_LO;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            imm_q   <= '0;
            instr_q <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= ADDR_W'(START_ADDR);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            imm_q   <= imm_d;
            instr_q <= instr_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign addr_o        = addr_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases with literal expectations, then random requests
// checked against an arithmetic encoding model and a decode round trip.
module tb_instr_encoder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i, rs1_i, rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic [2:0]        state_o;

    instr_encoder #(.ADDR_W(ADDR_W), .START_ADDR(0), .EXPAND_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int err_exp  = 0;
    int err_seen = 0;
    int model_addr = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_imm_q[$];
    bit          exp_rt_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void push_word(input logic [31:0] w, input bit rt, input logic [31:0] imm);
        exp_q.push_back(w);
        exp_addr_q.push_back(32'(model_addr));
        exp_rt_q.push_back(rt);
        exp_imm_q.push_back(imm);
        model_addr = (model_addr + 4) % (1 << ADDR_W);
    endfunction

    // Reference: what the encoder must emit for one request, from plain arithmetic.
    function automatic void model_push(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm);
        int          s;
        bit          ok;
        bit          rt;
        logic [31:0] w;
        logic [31:0] regs;
        longint      lo_s;
        longint      hi;
        s    = $signed(imm);
        ok   = 1'b0;
        rt   = 1'b1;
        w    = 32'd0;
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (imm < 32);
                    rt = 1'b0;
                    w  = (32'(f7) << 25) | ((imm & 32'd31) << 20) | regs | (32'(rd) << 7);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w  = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
                end
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((imm >> 5) & 32'd127) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'd31) << 7);
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
                w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (32'(rs2) << 20)
                   | regs | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7);
            end
            7'h6F: begin
                ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
                w  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                   | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12)
                   | (32'(rd) << 7) | 32'(op);
            end
            7'h17: begin
                ok = ((imm & 32'hFFF) == 0);
                w  = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
            end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            push_word(w, rt, imm);
        end else if (op == 7'h13 && f3 == 3'd0) begin
            // value = hi*4096 + signed(lo)
            lo_s = longint'(imm & 32'hFFF);
            if (lo_s >= 2048) lo_s = lo_s - 4096;
            hi = ((longint'(s) - lo_s) >>> 12) & 64'hFFFFF;
            push_word((32'(hi) << 12) | (32'(rd) << 7) | 32'h37, 1'b0, imm);
            push_word(((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13, 1'b0, imm);
        end else begin
            err_exp++;
        end
    endfunction

    // Core-side immediate decode used for the round trip.
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        case (w[6:0])
            7'h23:   decode_imm = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:   decode_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F:   decode_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            7'h17:   decode_imm = {w[31:12], 12'd0};
            default: decode_imm = {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_i && instr_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", instr_o, 32'hxxxx_xxxx);
            end else begin
                chk("instr", instr_o, exp_q[0]);
                chk("addr", 32'(addr_o), exp_addr_q[0]);
                if (instr_ready_i) begin
                    if (exp_rt_q[0]) chk("roundtrip", decode_imm(instr_o), exp_imm_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_addr_q.pop_front());
                    void'(exp_rt_q.pop_front());
                    void'(exp_imm_q.pop_front());
                end
            end
        end
        if (!rst_i && err_o) begin
            err_seen++;
            chk("err_without_valid", 32'(instr_valid_o), 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) instr_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            chk("req_ready_timeout", 32'(req_ready_o), 32'd1);
            return;
        end
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        req_valid_i = 1'b1;
        model_push(op, rd, rs1, rs2, f3, f7, imm);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        int          n;
        rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b1;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;
        #12;
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        @(posedge clk); #1 rst_i = 1'b0;

        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_check_valid", 32'(instr_valid_o), 32'd0);
        chk("t1_busy", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(instr_valid_o), 32'd1);
        chk("t1_instr", instr_o, 32'hFFF0_0293);
        chk("t1_addr", 32'(addr_o), 32'd0);
        @(negedge clk);
        chk("t1_addr_after", 32'(addr_o), 32'd4);

        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk); @(negedge clk);
        chk("t2_instr", instr_o, 32'h0020_A423);
        chk("t2_addr", 32'(addr_o), 32'd4);

        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        @(negedge clk); @(negedge clk);
        chk("t3_lui", instr_o, 32'h1234_60B7);
        chk("t3_lui_addr", 32'(addr_o), 32'd8);
        @(negedge clk);
        chk("t3_gap", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        chk("t3_addi", instr_o, 32'hFFF0_8093);
        chk("t3_addi_addr", 32'(addr_o), 32'd12);
        @(negedge clk);
        chk("t3_addr_after", 32'(addr_o), 32'd16);

        send(7'h63, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        chk("t4_no_err_yet", 32'(err_o), 32'd0);
        @(negedge clk);
        chk("t4_err", 32'(err_o), 32'd1);
        chk("t4_no_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        chk("t4_err_drop", 32'(err_o), 32'd0);
        chk("t4_addr", 32'(addr_o), 32'd16);
        chk("t4_ready", 32'(req_ready_o), 32'd1);

        instr_ready_i = 1'b0;
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(instr_valid_o), 32'd1);
            chk("t5_hold_instr", instr_o, 32'h0020_A423);
            chk("t5_hold_addr", 32'(addr_o), 32'd16);
            chk("t5_hold_busy", 32'(req_ready_o), 32'd0);
        end
        @(posedge clk); #1 instr_ready_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t5_addr_after", 32'(addr_o), 32'd20);
        chk("t5_ready_back", 32'(req_ready_o), 32'd1);

        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        @(negedge clk); @(negedge clk);
        chk("t6_lui_addr", 32'(addr_o), 32'd20);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("t6_rst_addr", 32'(addr_o), 32'd0);
        exp_q.delete(); exp_addr_q.delete(); exp_rt_q.delete(); exp_imm_q.delete();
        model_addr = 0;
        @(posedge clk); #1 rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_addi", 32'(instr_valid_o), 32'd0);
        end

        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1: begin
                    op = 7'h13; f3 = 3'd0;
                    imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4095) - 2048) : 32'($urandom);
                end
                2: begin
                    op = 7'h13;
                    imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'($urandom_range(0, 31))
                                                     : 32'($urandom_range(0, 4095) - 2048);
                end
                3: begin
                    op = ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h67;
                    imm = 32'($urandom_range(0, 4095) - 2048);
                end
                4: begin op = 7'h23; imm = 32'($urandom_range(0, 4095) - 2048); end
                5: begin op = 7'h63; imm = 32'(($urandom_range(0, 4095) - 2048) * 2); end
                6: begin op = 7'h6F; imm = 32'(($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2); end
                7: begin op = 7'h17; imm = 32'($urandom) & 32'hFFFF_F000; end
                8: begin op = 7'($urandom_range(0, 127)); imm = 32'($urandom_range(0, 4095) - 2048); end
                default: begin
                    case ($urandom_range(0, 3))
                        0: op = 7'h63;
                        1: op = 7'h6F;
                        2: op = 7'h17;
                        default: op = 7'h23;
                    endcase
                    imm = 32'($urandom);
                end
            endcase
            send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 f3, 7'($urandom_range(0, 127)), imm);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 instr_ready_i = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("err_count", 32'(err_seen), 32'(err_exp));
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
